// File: rtl/exp7_pkg_detector.sv
// Shared definitions for the jogada detector: FSM state encoding, default
// debounce length and the one-hot test used to validate a debounced press.
package exp7_pkg_detector;

    localparam int DEBOUNCE_CYCLES_PADRAO = 50000;

    typedef enum logic [2:0] {
        INICIAL        = 3'd0,
        ESPERA_PRESS   = 3'd1,
        DEBOUNCE_PRESS = 3'd2,
        EMITE          = 3'd3,
        ESPERA_SOLTA   = 3'd4,
        DEBOUNCE_SOLTA = 3'd5
    } estado_t;

    // True when exactly one bit is set; callers zero-extend narrower buses.
    function automatic logic eh_one_hot(input logic [31:0] vec);
        return (vec != 32'd0) && ((vec & (vec - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/exp7_contador_debounce.sv
// Debounce counter: clear has priority over count; fim flags the last
// count of a stable window so the FSM can leave the debounce state.
module exp7_contador_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    logic [CNT_W-1:0] valor_reg;

    always_ff @(posedge clock) begin
        if (reset || zera) begin
            valor_reg <= '0;
        end else if (conta) begin
            valor_reg <= valor_reg + CNT_W'(1);
        end
    end

    assign fim = (valor_reg == CNT_W'(DEBOUNCE_CYCLES - 1));

endmodule

// File: rtl/exp7_detector_jogada.sv
// Button front end for the memory game: synchronizes and debounces botoes
// and reports one accepted press per push to the control unit.
module exp7_detector_jogada
    import exp7_pkg_detector::*;
#(
    parameter int N_BOTOES        = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_PADRAO,
    parameter int CNT_W           = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_BOTOES-1:0] botoes,
    input  logic                habilita,
    output logic                jogada_feita,
    output logic [N_BOTOES-1:0] jogada,
    output logic                jogada_invalida,
    output logic                ocupado,
    output logic [2:0]          db_estado
);

    logic [N_BOTOES-1:0] meta_reg;
    logic [N_BOTOES-1:0] sinc_reg;
    logic [N_BOTOES-1:0] amostra_reg;
    logic [N_BOTOES-1:0] amostra_next;
    logic [N_BOTOES-1:0] jogada_reg;
    logic [N_BOTOES-1:0] jogada_next;
    estado_t             estado_reg;
    estado_t             estado_next;
    logic                zera;
    logic                conta;
    logic                fim;
    logic                amostra_valida;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta_reg <= '0;
            sinc_reg <= '0;
        end else begin
            meta_reg <= botoes;
            sinc_reg <= meta_reg;
        end
    end

    exp7_contador_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_contador (
        .clock(clock),
        .reset(reset),
        .zera (zera),
        .conta(conta),
        .fim  (fim)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_reg  <= INICIAL;
            amostra_reg <= '0;
            jogada_reg  <= '0;
        end else begin
            estado_reg  <= estado_next;
            amostra_reg <= amostra_next;
            jogada_reg  <= jogada_next;
        end
    end

    assign amostra_valida = eh_one_hot(32'(amostra_reg));

    always_comb begin
        estado_next  = estado_reg;
        amostra_next = amostra_reg;
        jogada_next  = jogada_reg;
        zera         = 1'b0;
        conta        = 1'b0;
        case (estado_reg)
            // Start by demanding a release so a button held through reset never counts.
            INICIAL: estado_next = ESPERA_SOLTA;
            ESPERA_PRESS: begin
                if (sinc_reg != '0) begin
                    amostra_next = sinc_reg;
                    zera         = 1'b1;
                    estado_next  = DEBOUNCE_PRESS;
                end
            end
            DEBOUNCE_PRESS: begin
                if (sinc_reg == '0) begin
                    estado_next = ESPERA_PRESS;
                end else if (sinc_reg != amostra_reg) begin
                    amostra_next = sinc_reg;
                    zera         = 1'b1;
                end else if (fim) begin
                    estado_next = EMITE;
                end else begin
                    conta = 1'b1;
                end
            end
            EMITE: begin
                if (habilita && amostra_valida) begin
                    jogada_next = amostra_reg;
                end
                estado_next = ESPERA_SOLTA;
            end
            ESPERA_SOLTA: begin
                if (sinc_reg == '0) begin
                    zera        = 1'b1;
                    estado_next = DEBOUNCE_SOLTA;
                end
            end
            DEBOUNCE_SOLTA: begin
                if (sinc_reg != '0) begin
                    estado_next = ESPERA_SOLTA;
                end else if (fim) begin
                    estado_next = ESPERA_PRESS;
                end else begin
                    conta = 1'b1;
                end
            end
            default: estado_next = INICIAL;
        endcase
    end

    assign jogada_feita    = (estado_reg == EMITE) && habilita && amostra_valida;
    assign jogada_invalida = (estado_reg == EMITE) && habilita && !amostra_valida;
    assign ocupado         = (estado_reg == DEBOUNCE_PRESS) || (estado_reg == EMITE) ||
                             (estado_reg == ESPERA_SOLTA)   || (estado_reg == DEBOUNCE_SOLTA);
    assign jogada          = jogada_reg;
    assign db_estado       = estado_reg;

endmodule

// File: tb/tb_exp7_detector_jogada.sv
// Directed bench for exp7_detector_jogada with a short debounce window;
// expected press outcomes are queued at stimulus time and checked on output.
module tb_exp7_detector_jogada;

    localparam int NB = 4;
    localparam int DC = 4;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic [NB-1:0] botoes;
    logic          habilita;
    logic          jogada_feita;
    logic [NB-1:0] jogada;
    logic          jogada_invalida;
    logic          ocupado;
    logic [2:0]    db_estado;

    typedef struct {
        logic          feita;
        logic          invalida;
        logic [NB-1:0] jogada;
    } esperado_t;

    esperado_t fila[$];
    int n_assert   = 0;
    int n_falhas   = 0;
    int n_feita    = 0;
    int n_invalida = 0;
    int base;

    exp7_detector_jogada #(
        .N_BOTOES       (NB),
        .DEBOUNCE_CYCLES(DC),
        .CNT_W          (CW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .botoes         (botoes),
        .habilita       (habilita),
        .jogada_feita   (jogada_feita),
        .jogada         (jogada),
        .jogada_invalida(jogada_invalida),
        .ocupado        (ocupado),
        .db_estado      (db_estado)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (jogada_feita)    n_feita++;
        if (jogada_invalida) n_invalida++;
    end

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_falhas++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic borda();
        @(posedge clock);
        #1;
    endtask

    task automatic espera(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pressiona(input logic [NB-1:0] b, input logic f, input logic inv,
                             input logic [NB-1:0] j);
        esperado_t e;
        borda();
        botoes = b;
        e.feita = f;
        e.invalida = inv;
        e.jogada = j;
        fila.push_back(e);
    endtask

    // The cycle botoes changes in counts as cycle 1, so a clean press pulses in cycle DC+4.
    task automatic aguarda_evento(input string tag, input int limite, input int lat_esperada);
        esperado_t e;
        logic f = 1'b0;
        logic inv = 1'b0;
        int lat = 0;
        for (int i = 1; i <= limite; i++) begin
            @(negedge clock);
            if (jogada_feita || jogada_invalida) begin
                f = jogada_feita;
                inv = jogada_invalida;
                lat = i;
                break;
            end
        end
        e = fila.pop_front();
        verifica({tag, " feita"}, 32'(f), 32'(e.feita));
        verifica({tag, " invalida"}, 32'(inv), 32'(e.invalida));
        if (lat_esperada > 0) verifica({tag, " latencia"}, lat, lat_esperada);
        if (f || inv) begin
            @(negedge clock);
            verifica({tag, " pulso unico"}, 32'(jogada_feita | jogada_invalida), 0);
        end
        verifica({tag, " jogada"}, 32'(jogada), 32'(e.jogada));
    endtask

    task automatic solta();
        borda();
        botoes = '0;
        espera(12);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        habilita = 1'b1;
        botoes   = 4'b0001;
        espera(3);
        @(negedge clock);
        verifica("reset estado", 32'(db_estado), 0);
        verifica("reset jogada", 32'(jogada), 0);
        verifica("reset feita", 32'(jogada_feita), 0);
        verifica("reset invalida", 32'(jogada_invalida), 0);
        verifica("reset ocupado", 32'(ocupado), 0);

        // Button held through reset must not count.
        borda();
        reset = 1'b0;
        espera(20);
        @(negedge clock);
        verifica("segurado n_feita", n_feita, 0);
        verifica("segurado estado", 32'(db_estado), 4);
        verifica("segurado jogada", 32'(jogada), 0);
        verifica("segurado ocupado", 32'(ocupado), 1);
        solta();
        @(negedge clock);
        verifica("solto estado", 32'(db_estado), 1);
        verifica("solto ocupado", 32'(ocupado), 0);

        pressiona(4'b0100, 1'b1, 1'b0, 4'b0100);
        aguarda_evento("limpo", 30, DC + 4);
        solta();
        @(negedge clock);
        verifica("limpo apos soltar jogada", 32'(jogada), 32'h4);
        verifica("limpo apos soltar estado", 32'(db_estado), 1);

        // Bounce: 2-cycle pulses never fill the window; only the final hold counts.
        base = n_feita;
        for (int k = 0; k < 6; k++) begin
            borda();
            botoes = (k % 2 == 0) ? 4'b0010 : 4'b0000;
            @(posedge clock);
        end
        pressiona(4'b0010, 1'b1, 1'b0, 4'b0010);
        aguarda_evento("rebote", 30, 0);
        solta();
        verifica("rebote n_feita", n_feita - base, 1);

        pressiona(4'b0011, 1'b0, 1'b1, 4'b0010);
        aguarda_evento("dois botoes", 30, DC + 4);
        solta();
        verifica("dois botoes n_invalida", n_invalida, 1);

        borda();
        habilita = 1'b0;
        pressiona(4'b1000, 1'b0, 1'b0, 4'b0010);
        aguarda_evento("desabilitado", 20, 0);
        verifica("desabilitado ocupado", 32'(ocupado), 1);
        verifica("desabilitado estado", 32'(db_estado), 4);
        solta();
        @(negedge clock);
        verifica("desabilitado solto ocupado", 32'(ocupado), 0);
        borda();
        habilita = 1'b1;
        pressiona(4'b0001, 1'b1, 1'b0, 4'b0001);
        aguarda_evento("reabilitado", 30, DC + 4);
        solta();

        // Reset while the press is still being debounced.
        borda();
        botoes = 4'b0100;
        repeat (4) @(negedge clock);
        verifica("meio debounce estado", 32'(db_estado), 2);
        verifica("meio debounce ocupado", 32'(ocupado), 1);
        borda();
        reset = 1'b1;
        borda();
        @(negedge clock);
        verifica("reset meio estado", 32'(db_estado), 0);
        verifica("reset meio jogada", 32'(jogada), 0);
        verifica("reset meio ocupado", 32'(ocupado), 0);
        verifica("reset meio feita", 32'(jogada_feita), 0);
        base = n_feita;
        borda();
        reset = 1'b0;
        espera(15);
        @(negedge clock);
        verifica("pos reset n_feita", n_feita - base, 0);
        verifica("pos reset estado", 32'(db_estado), 4);
        solta();
        pressiona(4'b0010, 1'b1, 1'b0, 4'b0010);
        aguarda_evento("apos reset", 30, DC + 4);
        solta();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_falhas);
        $finish;
    end

endmodule
